pong_engine: RTL and testbench

- Parametrised successor to the single-player pong pixel generator.
- Owns paddle and ball motion, collision, a speed ramp, score and lives, plus a game-state FSM (SERVE/PLAY/MISS/OVER).
- Renders 12-bit BGR pixels for the VGA timing front-end.
- Sits between the VGA sync generator (supplies x, y, video_on) and the debounced buttons; score drives the seven-segment display block.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/pong_ball_rom.sv | 14 +
 rtl/pong_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_pong_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong engine: state encoding, palette, ball sprite
// and the helper that centres objects on the screen.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_MISS  = 2'b10,
    ST_OVER  = 2'b11
  } game_state_t;

  localparam logic [11:0] COLOR_BLANK   = 12'h000;
  localparam logic [11:0] COLOR_WALL    = 12'h111;
  localparam logic [11:0] COLOR_PAD     = 12'h111;
  localparam logic [11:0] COLOR_BALL    = 12'h1FF;
  localparam logic [11:0] COLOR_BG      = 12'hCCC;
  localparam logic [11:0] COLOR_BG_OVER = 12'h00F;

  localparam int SPRITE_ROWS = 12;

  // Row 0 is the top of the ball; bit 11 is the leftmost column.
  localparam logic [0:SPRITE_ROWS-1][11:0] BALL_SPRITE = {
    12'h0F0, 12'h3FC, 12'h7FE, 12'h7FE, 12'hFFF, 12'hFFF,
    12'hFFF, 12'hFFF, 12'h7FE, 12'h7FE, 12'h3FC, 12'h0F0
  };

  function automatic logic [9:0] centre_pos(input int span, input int size);
    return 10'((span - size) / 2);
  endfunction

endpackage

// File: rtl/pong_ball_rom.sv
// Round ball sprite lookup: one 12-bit row per address, blank outside the sprite.
module pong_ball_rom
  import pong_pkg::*;
(
  input  logic [9:0]  row,
  output logic [11:0] row_bits
);

  always_comb begin
    row_bits = '0;
    if (row < 10'(SPRITE_ROWS)) row_bits = BALL_SPRITE[row[3:0]];
  end

endmodule

// File: rtl/pong_engine.sv
// Single-player pong: paddle and ball motion, scoring, lives, game-state FSM
// and the pixel renderer driven by the VGA sync generator's x/y.
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int WALL_L      = 77,
  parameter int WALL_R      = 84,
  parameter int PAD_X_L     = 620,
  parameter int PAD_W       = 5,
  parameter int PAD_H       = 98,
  parameter int PAD_STEP    = 2,
  parameter int BALL_SIZE   = 12,
  parameter int BALL_V0     = 3,
  parameter int SPEED_MAX   = 4,
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60,
  parameter int SCORE_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               serve,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  output logic [11:0]        rgb,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives_left,
  output logic [1:0]         game_state
);

  localparam int SPD_W  = $clog2(SPEED_MAX + 1);
  localparam int MISS_W = $clog2(MISS_FRAMES + 1);

  localparam logic [10:0] K_H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] K_V_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] K_BALL     = 11'(BALL_SIZE);
  localparam logic [10:0] K_BALL_M1  = 11'(BALL_SIZE - 1);
  localparam logic [10:0] K_BALL_YMX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] K_HIT_X    = 11'(PAD_X_L - BALL_SIZE);
  localparam logic [10:0] K_PARK_X   = 11'(WALL_R + 1);
  localparam logic [10:0] K_WALL_L   = 11'(WALL_L);
  localparam logic [10:0] K_WALL_R   = 11'(WALL_R);
  localparam logic [10:0] K_PAD_XL   = 11'(PAD_X_L);
  localparam logic [10:0] K_PAD_XR   = 11'(PAD_X_L + PAD_W - 1);
  localparam logic [10:0] K_PAD_M1   = 11'(PAD_H - 1);
  localparam logic [10:0] K_PAD_MAX  = 11'(V_ACTIVE - PAD_H);
  localparam logic [10:0] K_STEP     = 11'(PAD_STEP);
  localparam logic [10:0] K_V0       = 11'(BALL_V0);

  localparam logic [9:0] PARK_X   = 10'(WALL_R + 1);
  localparam logic [9:0] PARK_Y   = centre_pos(V_ACTIVE, BALL_SIZE);
  localparam logic [9:0] PAD_HOME = centre_pos(V_ACTIVE, PAD_H);

  game_state_t       state;
  logic [9:0]        ball_x, ball_y, pad_top;
  logic              dir_x, dir_y;  // 1 = right / down
  logic [SPD_W-1:0]  speed_inc;
  logic [MISS_W-1:0] miss_cnt;

  logic        frame_tick;
  logic [10:0] bx, by, pt, xx, yy, dx, dy;
  logic [9:0]  next_x, next_y, next_pad;
  logic        next_dir_x, next_dir_y, hit, miss, overlap;

  assign frame_tick = (y == 10'(V_ACTIVE + 1)) && (x == '0);
  assign game_state = state;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pt = {1'b0, pad_top};
  assign xx = {1'b0, x};
  assign yy = {1'b0, y};
  assign dx = K_V0 + 11'(speed_inc);
  assign dy = K_V0;
  assign overlap = (by <= pt + K_PAD_M1) && (by + K_BALL_M1 >= pt);

  // Axes are resolved independently; magnitudes only, direction in separate bits.
  always_comb begin
    next_y     = ball_y;
    next_dir_y = dir_y;
    next_x     = ball_x;
    next_dir_x = dir_x;
    hit        = 1'b0;
    miss       = 1'b0;
    next_pad   = pad_top;

    if (!dir_y) begin
      if (by < dy) begin
        next_y     = '0;
        next_dir_y = 1'b1;
      end else begin
        next_y = 10'(by - dy);
      end
    end else if (by + K_BALL_M1 + dy > K_V_LAST) begin
      next_y     = 10'(K_BALL_YMX);
      next_dir_y = 1'b0;
    end else begin
      next_y = 10'(by + dy);
    end

    if (!dir_x) begin
      if (bx < K_PARK_X + dx) begin
        next_x     = PARK_X;
        next_dir_x = 1'b1;
      end else begin
        next_x = 10'(bx - dx);
      end
    end else if ((bx + K_BALL_M1 + dx >= K_PAD_XL) && overlap) begin
      hit        = 1'b1;
      next_x     = 10'(K_HIT_X);
      next_dir_x = 1'b0;
    end else if (bx + K_BALL_M1 + dx > K_H_LAST) begin
      miss = 1'b1;
    end else begin
      next_x = 10'(bx + dx);
    end

    if (up) begin
      next_pad = (pt >= K_STEP) ? 10'(pt - K_STEP) : '0;
    end else if (down) begin
      next_pad = (pt + K_STEP > K_PAD_MAX) ? 10'(K_PAD_MAX) : 10'(pt + K_STEP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_SERVE;
      score      <= '0;
      lives_left <= 3'(LIVES);
      speed_inc  <= '0;
      miss_cnt   <= '0;
      pad_top    <= PAD_HOME;
      ball_x     <= PARK_X;
      ball_y     <= PARK_Y;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
    end else begin
      case (state)
        ST_SERVE: begin
          // Serve beats a coincident frame tick: the ball stays parked this frame.
          if (serve) begin
            state <= ST_PLAY;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            ball_y <= next_y;
            dir_y  <= next_dir_y;
            if (miss) begin
              state      <= ST_MISS;
              lives_left <= lives_left - 3'd1;
              speed_inc  <= '0;
              miss_cnt   <= '0;
            end else begin
              ball_x <= next_x;
              dir_x  <= next_dir_x;
            end
            if (hit) begin
              if (score != '1) score <= score + 1'b1;
              if (speed_inc < SPD_W'(SPEED_MAX)) speed_inc <= speed_inc + 1'b1;
            end
          end
        end
        ST_MISS: begin
          if (frame_tick) begin
            if (miss_cnt == MISS_W'(MISS_FRAMES - 1)) begin
              miss_cnt <= '0;
              state    <= (lives_left == 3'd0) ? ST_OVER : ST_SERVE;
              ball_x   <= PARK_X;
              ball_y   <= PARK_Y;
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (serve) begin
            state      <= ST_SERVE;
            score      <= '0;
            lives_left <= 3'(LIVES);
            speed_inc  <= '0;
            ball_x     <= PARK_X;
            ball_y     <= PARK_Y;
          end
        end
        default: state <= ST_SERVE;
      endcase

      if (frame_tick && (state != ST_OVER)) pad_top <= next_pad;
    end
  end

  logic [9:0]  spr_row, spr_col;
  logic [11:0] spr_bits;
  logic        wall_on, pad_on, box_on, sprite_bit, ball_on;

  assign spr_row = y - ball_y;
  assign spr_col = x - ball_x;

  pong_ball_rom u_ball_rom (
    .row      (spr_row),
    .row_bits (spr_bits)
  );

  assign wall_on    = (xx >= K_WALL_L) && (xx <= K_WALL_R);
  assign pad_on     = (xx >= K_PAD_XL) && (xx <= K_PAD_XR) && (yy >= pt) && (yy <= pt + K_PAD_M1);
  assign box_on     = (xx >= bx) && (xx < bx + K_BALL) && (yy >= by) && (yy < by + K_BALL);
  assign sprite_bit = (spr_col < 10'd12) ? spr_bits[4'd11 - spr_col[3:0]] : 1'b0;
  assign ball_on    = box_on && ((state == ST_SERVE) || (state == ST_PLAY)) &&
                      ((BALL_SIZE != 12) || sprite_bit);

  always_comb begin
    rgb = (state == ST_OVER) ? COLOR_BG_OVER : COLOR_BG;
    if (!video_on)    rgb = COLOR_BLANK;
    else if (wall_on) rgb = COLOR_WALL;
    else if (pad_on)  rgb = COLOR_PAD;
    else if (ball_on) rgb = COLOR_BALL;
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: a full game with hand-computed ball and paddle
// trajectories, five paddle hits, three misses, game over and restart.
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        reset, up, down, serve, video_on;
  logic [9:0]  x, y;
  logic [11:0] rgb;
  logic [15:0] score;
  logic [2:0]  lives_left;
  logic [1:0]  game_state;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_n   = 0;

  localparam logic [11:0] C_BG   = 12'hCCC;
  localparam logic [11:0] C_OVER = 12'h00F;
  localparam logic [11:0] C_WALL = 12'h111;
  localparam logic [11:0] C_BALL = 12'h1FF;

  pong_engine dut (
    .clk        (clk),
    .reset      (reset),
    .up         (up),
    .down       (down),
    .serve      (serve),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .rgb        (rgb),
    .score      (score),
    .lives_left (lives_left),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic check_px(input string tag, input int px, input int py, input logic [11:0] exp);
    x = 10'(px);
    y = 10'(py);
    #1;
    check(tag, {4'h0, rgb}, {4'h0, exp});
  endtask

  // One frame tick: the (0, 481) pixel is presented across exactly one rising edge.
  task automatic tick();
    @(negedge clk);
    x = 10'd0;
    y = 10'd481;
    @(negedge clk);
    x = 10'd300;
    y = 10'd200;
  endtask

  task automatic run_to(input int t);
    while (tick_n < t) begin
      tick();
      tick_n++;
    end
  endtask

  task automatic pulse_serve();
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  initial begin
    reset = 1'b0; up = 1'b0; down = 1'b0; serve = 1'b0; video_on = 1'b1;
    x = 10'd300; y = 10'd200;

    // Asynchronous reset in the middle of a frame, between clock edges.
    #12 reset = 1'b1;
    #1;
    check("rst_state", {14'd0, game_state}, 16'h0000);
    check("rst_score", score, 16'd0);
    check("rst_lives", {13'd0, lives_left}, 16'd3);
    check_px("rst_ball_centre", 91, 240, C_BALL);
    check_px("rst_ball_corner", 85, 234, C_BG);
    @(negedge clk);
    reset = 1'b0;

    tick(); tick(); tick();
    check("serve_idle_state", {14'd0, game_state}, 16'h0000);
    check_px("serve_idle_ball", 91, 240, C_BALL);
    check_px("pad_top_row", 620, 191, C_WALL);
    check_px("pad_above", 620, 190, C_BG);
    check_px("pad_bottom_row", 624, 288, C_WALL);
    check_px("pad_right_of", 625, 288, C_BG);
    check_px("wall_pixel", 80, 10, C_WALL);

    // Round 1: ball path is x = 85+3T, y = 234+3T until the first bounce.
    pulse_serve();
    check("play_state", {14'd0, game_state}, 16'h0001);
    tick_n = 0;
    run_to(10);
    check_px("t10_ball_left_col", 115, 270, C_BALL);
    check_px("t10_before_ball", 114, 270, C_BG);
    run_to(174);
    check("pre_hit_score", score, 16'd0);
    run_to(175);
    check("hit1_score", score, 16'd1);
    check_px("hit1_ball_x608", 608, 186, C_BALL);
    check_px("hit1_left_of_ball", 607, 186, C_BG);
    run_to(176);
    check_px("dx4_ball_x604", 604, 183, C_BALL);
    check_px("dx4_left_of_ball", 603, 183, C_BG);
    check("hit_counted_once", score, 16'd1);

    run_to(199); down = 1'b1; run_to(225); down = 1'b0;
    run_to(437);
    check("hit2_score", score, 16'd2);
    run_to(647);
    check("hit3_score", score, 16'd3);
    run_to(659); up = 1'b1; run_to(719); up = 1'b0;
    run_to(823);
    check("hit4_score", score, 16'd4);
    run_to(829); down = 1'b1; run_to(884); down = 1'b0;
    run_to(973);
    check("hit5_score", score, 16'd5);
    run_to(974);
    check_px("dx_sat_left_of_ball", 600, 336, C_BG);
    check_px("dx_sat_ball_x601", 601, 336, C_BALL);

    // Paddle from 233 upwards to the top boundary.
    up = 1'b1;
    run_to(1090);
    check_px("pad_top1_row0", 620, 0, C_BG);
    check_px("pad_top1_row1", 620, 1, C_WALL);
    run_to(1091);
    check_px("pad_top0_row0", 620, 0, C_WALL);
    run_to(1092);
    check_px("pad_clamp_row0", 620, 0, C_WALL);
    check_px("pad_clamp_row97", 620, 97, C_WALL);
    check_px("pad_clamp_row98", 620, 98, C_BG);
    down = 1'b1;
    run_to(1093);
    up = 1'b0; down = 1'b0;
    check_px("up_priority_row0", 620, 0, C_WALL);
    check_px("up_priority_row98", 620, 98, C_BG);

    run_to(1125);
    check("before_miss_state", {14'd0, game_state}, 16'h0001);
    run_to(1126);
    check("miss1_state", {14'd0, game_state}, 16'h0002);
    check("miss1_lives", {13'd0, lives_left}, 16'd2);
    check_px("miss1_ball_hidden", 630, 159, C_BG);
    pulse_serve();
    check("miss_ignores_serve", {14'd0, game_state}, 16'h0002);
    run_to(1185);
    check("miss_59_ticks", {14'd0, game_state}, 16'h0002);
    run_to(1186);
    check("miss_60_to_serve", {14'd0, game_state}, 16'h0000);
    check("score_kept", score, 16'd5);
    check_px("reparked_ball", 91, 240, C_BALL);

    // Round 2: paddle parked at top 0, ball misses at tick 182.
    pulse_serve();
    tick_n = 0;
    run_to(181);
    check("r2_still_play", {14'd0, game_state}, 16'h0001);
    run_to(182);
    check("r2_miss_state", {14'd0, game_state}, 16'h0002);
    check("r2_lives", {13'd0, lives_left}, 16'd1);
    run_to(242);
    check("r2_back_to_serve", {14'd0, game_state}, 16'h0000);

    // Round 3: serve coincides with a frame tick; the ball must not move.
    @(negedge clk);
    serve = 1'b1; x = 10'd0; y = 10'd481;
    @(negedge clk);
    serve = 1'b0; x = 10'd300; y = 10'd200;
    check("r3_play_state", {14'd0, game_state}, 16'h0001);
    check_px("r3_ball_unmoved", 91, 240, C_BALL);
    tick_n = 0;
    run_to(182);
    check("r3_miss_state", {14'd0, game_state}, 16'h0002);
    check("r3_lives", {13'd0, lives_left}, 16'd0);
    run_to(241);
    check("r3_miss_59", {14'd0, game_state}, 16'h0002);
    run_to(242);
    check("over_state", {14'd0, game_state}, 16'h0003);
    check("over_lives", {13'd0, lives_left}, 16'd0);
    check("over_score_held", score, 16'd5);
    check_px("over_background", 300, 200, C_OVER);
    check_px("over_ball_hidden", 91, 240, C_OVER);
    check_px("over_wall", 80, 200, C_WALL);
    check_px("over_paddle", 620, 50, C_WALL);
    down = 1'b1;
    tick();
    down = 1'b0;
    check_px("over_paddle_frozen", 620, 98, C_OVER);

    pulse_serve();
    check("restart_state", {14'd0, game_state}, 16'h0000);
    check("restart_score", score, 16'd0);
    check("restart_lives", {13'd0, lives_left}, 16'd3);
    check_px("restart_ball", 91, 240, C_BALL);
    video_on = 1'b0;
    check_px("blank_ball", 91, 240, 12'h000);
    check_px("blank_wall", 80, 200, 12'h000);
    video_on = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
